// File: rtl/icache_axi_bridge_if.sv
// icache_axi_bridge_if: AXI4 read-address (AR) and read-data (R) channels between the icache bridge and the interconnect
//   arid/araddr/arlen/arsize/arburst/arvalid : AR payload and valid, driven by the master
//   arready                                  : AR ready, driven by the slave
//   rid/rdata/rresp/rlast/rvalid             : R payload and valid, driven by the slave
//   rready                                   : R ready, driven by the master
interface icache_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/icache_axi_bridge.sv
// icache_axi_bridge: read-only AXI4 master serving icache line refills (8-beat burst) and uncached single-word fetches
//   clk, reset_n                      : clock, asynchronous active-low reset
//   rd_req, rd_addr                   : cached line request (level) and line address
//   ret_valid, ret_data               : one-cycle line return pulse and assembled 256-bit line
//   iucache_ren_i, iucache_addr_i     : uncached fetch request (level) and word address
//   iucache_rvalid_o, iucache_rdata_o : one-cycle uncached return pulse and word
//   flush                             : discard the response of the transaction in flight
//   axi                               : AXI4 AR/R channels, master side
module icache_axi_bridge #(
   parameter logic [3:0] AXI_ID = 4'h0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rd_req,
   input  logic [31:0]         rd_addr,
   input  logic                flush,
   output logic                ret_valid,
   output logic [255:0]        ret_data,
   input  logic                iucache_ren_i,
   input  logic [31:0]         iucache_addr_i,
   output logic                iucache_rvalid_o,
   output logic [31:0]         iucache_rdata_o,
   icache_axi_bridge_if.master axi
);
   typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;
   state_t       r_state, w_next;
   logic         r_cached, r_drop;
   logic [2:0]   r_beat_cnt;
   logic [31:0]  r_araddr;
   logic [7:0]   r_arlen;
   logic [255:0] r_line;
   logic [31:0]  r_udata;
   logic         w_accept, w_beat, w_resp_ok, w_unused;
   assign w_accept  = (r_state == IDLE) && !flush && (rd_req || iucache_ren_i);
   assign w_beat    = (r_state == R) && axi.rvalid;
   // a flush landing on the RESP cycle itself must still kill the pulse, hence the live term
   assign w_resp_ok = (r_state == RESP) && !r_drop && !flush;
   assign w_unused  = ^{axi.rid, axi.rresp, rd_addr[4:0]};
   assign axi.arid        = AXI_ID;
   assign axi.arsize      = 3'b010;
   assign axi.arburst     = 2'b01;
   assign axi.araddr      = r_araddr;
   assign axi.arlen       = r_arlen;
   assign ret_data        = r_line;
   assign iucache_rdata_o = r_udata;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   // RESP always returns to IDLE so a still-held rd_req is never sampled twice
   always_comb begin
      w_next           = r_state;
      axi.arvalid      = (r_state == AR);
      axi.rready       = (r_state == R);
      ret_valid        = w_resp_ok && r_cached;
      iucache_rvalid_o = w_resp_ok && !r_cached;
      case (r_state)
         IDLE:    w_next = w_accept ? AR : IDLE;
         AR:      w_next = axi.arready ? R : AR;
         R:       w_next = (axi.rvalid && axi.rlast) ? RESP : R;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_cached   <= 1'b0;
         r_drop     <= 1'b0;
         r_beat_cnt <= 3'd0;
         r_araddr   <= 32'd0;
         r_arlen    <= 8'd0;
         r_line     <= 256'd0;
         r_udata    <= 32'd0;
      end else begin
         if (w_accept) begin
            r_cached   <= rd_req;
            r_araddr   <= rd_req ? {rd_addr[31:5], 5'b0} : iucache_addr_i;
            r_arlen    <= rd_req ? 8'd7 : 8'd0;
            r_drop     <= 1'b0;
            r_beat_cnt <= 3'd0;
         end
         if ((r_state == AR || r_state == R) && flush) r_drop <= 1'b1;
         // the slot index saturates, so stray beats before rlast keep landing in slot 7
         if (w_beat && r_cached) begin
            r_line[{r_beat_cnt, 5'b0} +: 32] <= axi.rdata;
            r_beat_cnt <= (r_beat_cnt == 3'd7) ? 3'd7 : r_beat_cnt + 3'd1;
         end
         if (w_beat && !r_cached) r_udata <= axi.rdata;
      end
endmodule

// File: tb/tb_icache_axi_bridge.sv
// tb_icache_axi_bridge: randomized self-checking bench for icache_axi_bridge with an AXI slave model and request-level reference
module tb_icache_axi_bridge;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         rd_req = 1'b0;
   logic [31:0]  rd_addr = 32'd0;
   logic         flush = 1'b0;
   logic         ret_valid;
   logic [255:0] ret_data;
   logic         iucache_ren_i = 1'b0;
   logic [31:0]  iucache_addr_i = 32'd0;
   logic         iucache_rvalid_o;
   logic [31:0]  iucache_rdata_o;
   icache_axi_bridge_if axi();
   icache_axi_bridge #(.AXI_ID(4'h0)) dut (
      .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_addr(rd_addr), .flush(flush),
      .ret_valid(ret_valid), .ret_data(ret_data), .iucache_ren_i(iucache_ren_i),
      .iucache_addr_i(iucache_addr_i), .iucache_rvalid_o(iucache_rvalid_o),
      .iucache_rdata_o(iucache_rdata_o), .axi(axi.master)
   );
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   int ar_delay = 0, gap_pct = 0;
   logic [31:0] words [8];
   int beats_left = 0, beat_idx = 0, ar_wait = 0;
   int cyc = 0, n_ar = 0, n_beats = 0, n_ret = 0, n_uret = 0;
   int arv_run = 0, hs_run = 0, hs_cyc = 0, ret_cyc = 0, last_beat_cyc = 0, first_arv_cyc = -1, first_beat_cyc = -1;
   logic        arv_unstable = 1'b0, ar_const_ok = 1'b1;
   logic [31:0] arv_addr = 32'd0;
   logic [31:0] ar_addr_q [$];
   logic [7:0]  ar_len_q [$];
   logic [255:0] last_ret = 256'd0;
   logic [31:0]  last_udata = 32'd0;
   // AXI slave: decides at the falling edge what the next rising edge sees
   initial begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = 32'd0; axi.rid = 4'd0; axi.rresp = 2'd0;
      forever begin
         @(negedge clk);
         axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
         axi.rid = 4'($urandom); axi.rresp = 2'($urandom);
         if (!reset_n) begin
            beats_left = 0; ar_wait = 0;
         end else begin
            if (axi.arvalid) begin
               if (ar_wait >= ar_delay) begin
                  axi.arready = 1'b1; ar_wait = 0; beats_left = int'(axi.arlen) + 1; beat_idx = 0;
               end else ar_wait++;
            end
            if (axi.rready && beats_left > 0 && int'($urandom_range(99)) >= gap_pct) begin
               axi.rvalid = 1'b1; axi.rdata = words[beat_idx]; axi.rlast = (beats_left == 1);
               beats_left--; beat_idx++;
            end
         end
      end
   end
   // monitor: samples after all stimulus for the cycle has settled
   initial forever begin
      @(negedge clk); #3;
      cyc++;
      if (axi.arvalid) begin
         if (arv_run == 0 && first_arv_cyc < 0) first_arv_cyc = cyc;
         if (arv_run > 0 && axi.araddr !== arv_addr) arv_unstable = 1'b1;
         arv_run++; arv_addr = axi.araddr;
         if (axi.arready) begin
            n_ar++; ar_addr_q.push_back(axi.araddr); ar_len_q.push_back(axi.arlen);
            if (axi.arsize !== 3'd2 || axi.arburst !== 2'd1 || axi.arid !== 4'd0) ar_const_ok = 1'b0;
            hs_run = arv_run; hs_cyc = cyc; arv_run = 0;
         end
      end else arv_run = 0;
      if (axi.rvalid && axi.rready) begin
         n_beats++; last_beat_cyc = cyc;
         if (n_beats == 1) first_beat_cyc = cyc;
      end
      if (ret_valid) begin n_ret++; last_ret = ret_data; ret_cyc = cyc; end
      if (iucache_rvalid_o) begin n_uret++; last_udata = iucache_rdata_o; ret_cyc = cyc; end
   end
   task automatic tick; @(negedge clk); #2; endtask
   task automatic clr;
      n_ar = 0; n_beats = 0; n_ret = 0; n_uret = 0; ar_addr_q.delete(); ar_len_q.delete();
      arv_unstable = 1'b0; ar_const_ok = 1'b1; first_arv_cyc = -1; first_beat_cyc = -1; hs_run = 0;
   endtask
   task automatic rand_words; for (int i = 0; i < 8; i++) words[i] = $urandom; endtask
   function automatic logic [255:0] line_of;
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = words[i];
      return l;
   endfunction
   task automatic wait_ret(input int target, input bit unc, input string nm);
      int k = 0;
      while ((unc ? n_uret : n_ret) < target && k < 300) begin tick; k++; end
      tests++; if (k >= 300) begin fails++; $display("FAIL %s: no response pulse within 300 cycles, got %0d want %0d", nm, unc ? n_uret : n_ret, target); end
   endtask
   task automatic wait_beats(input int target, input string nm);
      int k = 0;
      while (n_beats < target && k < 300) begin tick; k++; end
      tests++; if (k >= 300) begin fails++; $display("FAIL %s: beats got %0d want %0d within 300 cycles", nm, n_beats, target); end
   endtask
   task automatic test_reset;
      reset_n = 1'b0; tick; tick;
      tests++; if ({axi.arvalid, axi.rready, ret_valid, iucache_rvalid_o} !== 4'b0) begin fails++; $display("FAIL reset_ctl: got %b want 0000", {axi.arvalid, axi.rready, ret_valid, iucache_rvalid_o}); end
      tests++; if ({axi.araddr, axi.arlen} !== 40'd0) begin fails++; $display("FAIL reset_ar: got %h want 0", {axi.araddr, axi.arlen}); end
      tests++; if (ret_data !== 256'd0) begin fails++; $display("FAIL reset_ret_data: got %h want 0", ret_data); end
      tests++; if (iucache_rdata_o !== 32'd0) begin fails++; $display("FAIL reset_udata: got %h want 0", iucache_rdata_o); end
      tests++; if ({axi.arsize, axi.arburst, axi.arid} !== 9'b010_01_0000) begin fails++; $display("FAIL reset_const: got %b want 010010000", {axi.arsize, axi.arburst, axi.arid}); end
      reset_n = 1'b1; tick; tick;
   endtask
   task automatic test_cached;
      int req_cyc;
      clr; ar_delay = 0; gap_pct = 0;
      for (int i = 0; i < 8; i++) words[i] = i;
      rd_req = 1'b1; rd_addr = 32'h1C00_0044; req_cyc = cyc + 1;
      wait_ret(1, 1'b0, "cached_wait");
      rd_req = 1'b0; repeat (3) tick;
      tests++; if (n_ar !== 1) begin fails++; $display("FAIL cached_ar_count: got %0d want 1", n_ar); end
      tests++; if ((ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx) !== 32'h1C00_0040) begin fails++; $display("FAIL cached_araddr: got %h want 1c000040", ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx); end
      tests++; if ((ar_len_q.size() > 0 ? ar_len_q[0] : 8'hx) !== 8'd7) begin fails++; $display("FAIL cached_arlen: got %h want 07", ar_len_q.size() > 0 ? ar_len_q[0] : 8'hx); end
      tests++; if (ar_const_ok !== 1'b1) begin fails++; $display("FAIL cached_ar_const: got %b want 1", ar_const_ok); end
      tests++; if (n_ret !== 1) begin fails++; $display("FAIL cached_pulses: got %0d want 1", n_ret); end
      tests++; if (last_ret[31:0] !== 32'd0 || last_ret[255:224] !== 32'd7) begin fails++; $display("FAIL cached_ends: got %h/%h want 0/7", last_ret[31:0], last_ret[255:224]); end
      tests++; if (last_ret !== line_of()) begin fails++; $display("FAIL cached_line: got %h want %h", last_ret, line_of()); end
      tests++; if (first_arv_cyc !== req_cyc + 1) begin fails++; $display("FAIL cached_ar_latency: got %0d want %0d", first_arv_cyc, req_cyc + 1); end
      tests++; if (first_beat_cyc !== hs_cyc + 1) begin fails++; $display("FAIL cached_rready_latency: got %0d want %0d", first_beat_cyc, hs_cyc + 1); end
      tests++; if (ret_cyc !== last_beat_cyc + 1) begin fails++; $display("FAIL cached_resp_latency: got %0d want %0d", ret_cyc, last_beat_cyc + 1); end
   endtask
   task automatic test_back_to_back;
      logic [255:0] exp1;
      int r1;
      clr; rand_words; exp1 = line_of();
      rd_req = 1'b1; rd_addr = 32'h1C00_0020;
      wait_ret(1, 1'b0, "b2b_wait1");
      r1 = ret_cyc;
      tests++; if (last_ret !== exp1) begin fails++; $display("FAIL b2b_line1: got %h want %h", last_ret, exp1); end
      rand_words; rd_addr = 32'h1C00_0060;
      wait_ret(2, 1'b0, "b2b_wait2");
      rd_req = 1'b0; repeat (3) tick;
      tests++; if (n_ar !== 2) begin fails++; $display("FAIL b2b_ar_count: got %0d want 2", n_ar); end
      tests++; if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h1C00_0020 || ar_addr_q[1] !== 32'h1C00_0060) begin fails++; $display("FAIL b2b_addrs: got %p want 1c000020,1c000060", ar_addr_q); end
      tests++; if (hs_cyc !== r1 + 2) begin fails++; $display("FAIL b2b_second_ar: got cycle %0d want %0d", hs_cyc, r1 + 2); end
      tests++; if (last_ret !== line_of()) begin fails++; $display("FAIL b2b_line2: got %h want %h", last_ret, line_of()); end
   endtask
   task automatic test_uncached;
      clr; ar_delay = 3; rand_words;
      iucache_ren_i = 1'b1; iucache_addr_i = 32'hBFC0_0004;
      wait_ret(1, 1'b1, "unc_wait");
      iucache_ren_i = 1'b0; repeat (3) tick; ar_delay = 0;
      tests++; if (n_ar !== 1 || (ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx) !== 32'hBFC0_0004) begin fails++; $display("FAIL unc_ar: got count %0d addr %h want 1 bfc00004", n_ar, ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx); end
      tests++; if ((ar_len_q.size() > 0 ? ar_len_q[0] : 8'hx) !== 8'd0) begin fails++; $display("FAIL unc_arlen: got %h want 00", ar_len_q.size() > 0 ? ar_len_q[0] : 8'hx); end
      tests++; if (hs_run !== 4 || arv_unstable !== 1'b0) begin fails++; $display("FAIL unc_arvalid_hold: got %0d cycles unstable=%b want 4 0", hs_run, arv_unstable); end
      tests++; if (n_uret !== 1 || n_ret !== 0) begin fails++; $display("FAIL unc_pulses: got %0d/%0d want 1/0", n_uret, n_ret); end
      tests++; if (last_udata !== words[0]) begin fails++; $display("FAIL unc_data: got %h want %h", last_udata, words[0]); end
   endtask
   task automatic test_flush_ar;
      clr; ar_delay = 5; rand_words;
      rd_req = 1'b1; rd_addr = $urandom; tick;
      tests++; if (axi.arvalid !== 1'b1) begin fails++; $display("FAIL flush_ar_arvalid: got %b want 1", axi.arvalid); end
      flush = 1'b1; rd_req = 1'b0; tick; flush = 1'b0;
      wait_beats(8, "flush_ar_beats");
      repeat (4) tick; ar_delay = 0;
      tests++; if (hs_run !== 6) begin fails++; $display("FAIL flush_ar_hold: got %0d cycles want 6", hs_run); end
      tests++; if (n_beats !== 8 || n_ar !== 1) begin fails++; $display("FAIL flush_ar_complete: got beats %0d ar %0d want 8 1", n_beats, n_ar); end
      tests++; if (n_ret !== 0) begin fails++; $display("FAIL flush_ar_drop: got %0d pulses want 0", n_ret); end
      tests++; if ({axi.arvalid, axi.rready} !== 2'b00) begin fails++; $display("FAIL flush_ar_idle: got %b want 00", {axi.arvalid, axi.rready}); end
   endtask
   task automatic test_flush_resp;
      clr; rand_words;
      rd_req = 1'b1; rd_addr = $urandom;
      wait_beats(8, "flush_resp_beats");
      tests++; if ({axi.arvalid, axi.rready} !== 2'b00) begin fails++; $display("FAIL flush_resp_state: got %b want 00", {axi.arvalid, axi.rready}); end
      flush = 1'b1; tick; tick; flush = 1'b0;
      tests++; if (n_ret !== 0) begin fails++; $display("FAIL flush_resp_drop: got %0d pulses want 0", n_ret); end
      tests++; if (axi.arvalid !== 1'b0 || n_ar !== 1) begin fails++; $display("FAIL flush_idle_block: got arvalid %b ar %0d want 0 1", axi.arvalid, n_ar); end
      wait_ret(1, 1'b0, "flush_idle_retry");
      rd_req = 1'b0; repeat (3) tick;
      tests++; if (n_ar !== 2 || n_ret !== 1) begin fails++; $display("FAIL flush_retry_counts: got ar %0d pulses %0d want 2 1", n_ar, n_ret); end
      tests++; if (last_ret !== line_of()) begin fails++; $display("FAIL flush_retry_line: got %h want %h", last_ret, line_of()); end
   endtask
   task automatic test_random;
      bit cached, dofl;
      logic [31:0] addr, exp_addr;
      logic [7:0] exp_len;
      int k;
      for (int n = 0; n < 24; n++) begin
         clr; ar_delay = $urandom_range(3); gap_pct = 40; rand_words;
         cached = 1'($urandom_range(1)); dofl = ($urandom_range(3) == 0); addr = $urandom;
         exp_addr = cached ? {addr[31:5], 5'b0} : addr;
         exp_len = cached ? 8'd7 : 8'd0;
         if (cached) begin
            rd_req = 1'b1; rd_addr = addr; iucache_ren_i = 1'($urandom); iucache_addr_i = $urandom;
         end else begin
            iucache_ren_i = 1'b1; iucache_addr_i = addr;
         end
         if (dofl) begin
            k = 0;
            while (axi.rready !== 1'b1 && k < 100) begin tick; k++; end
            flush = 1'b1; rd_req = 1'b0; iucache_ren_i = 1'b0; tick; flush = 1'b0;
            wait_beats(int'(exp_len) + 1, "rand_flush_beats");
            repeat (3) tick;
         end else begin
            wait_ret(1, !cached, "rand_wait");
            rd_req = 1'b0; iucache_ren_i = 1'b0; repeat (2) tick;
         end
         tests++; if (n_ar !== 1 || (ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx) !== exp_addr || (ar_len_q.size() > 0 ? ar_len_q[0] : 8'hx) !== exp_len) begin fails++; $display("FAIL rand_ar[%0d]: got count %0d addr %h len %h want 1 %h %h", n, n_ar, ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx, ar_len_q.size() > 0 ? ar_len_q[0] : 8'hx, exp_addr, exp_len); end
         tests++; if (n_ret !== int'(cached && !dofl) || n_uret !== int'(!cached && !dofl)) begin fails++; $display("FAIL rand_pulses[%0d]: got %0d/%0d want %0d/%0d", n, n_ret, n_uret, int'(cached && !dofl), int'(!cached && !dofl)); end
         if (!dofl && cached) begin
            tests++; if (last_ret !== line_of()) begin fails++; $display("FAIL rand_line[%0d]: got %h want %h", n, last_ret, line_of()); end
         end
         if (!dofl && !cached) begin
            tests++; if (last_udata !== words[0]) begin fails++; $display("FAIL rand_word[%0d]: got %h want %h", n, last_udata, words[0]); end
         end
      end
      gap_pct = 0; ar_delay = 0;
   endtask
   task automatic test_reset_mid_burst;
      logic [31:0] addr;
      clr; gap_pct = 30; rand_words;
      rd_req = 1'b1; rd_addr = $urandom;
      wait_beats(3, "rst_mid_beats");
      reset_n = 1'b0; #1;
      tests++; if ({axi.arvalid, axi.rready, ret_valid, iucache_rvalid_o} !== 4'b0) begin fails++; $display("FAIL rst_mid_ctl: got %b want 0000", {axi.arvalid, axi.rready, ret_valid, iucache_rvalid_o}); end
      tests++; if ({axi.araddr, axi.arlen, iucache_rdata_o} !== 72'd0 || ret_data !== 256'd0) begin fails++; $display("FAIL rst_mid_data: got %h %h want 0", {axi.araddr, axi.arlen, iucache_rdata_o}, ret_data); end
      rd_req = 1'b0; tick; tick; reset_n = 1'b1; tick; gap_pct = 0;
      clr; rand_words; addr = $urandom;
      rd_req = 1'b1; rd_addr = addr;
      wait_ret(1, 1'b0, "rst_after_wait");
      rd_req = 1'b0; repeat (2) tick;
      tests++; if (n_ar !== 1 || (ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx) !== {addr[31:5], 5'b0}) begin fails++; $display("FAIL rst_after_ar: got count %0d addr %h want 1 %h", n_ar, ar_addr_q.size() > 0 ? ar_addr_q[0] : 32'hx, {addr[31:5], 5'b0}); end
      tests++; if (last_ret !== line_of()) begin fails++; $display("FAIL rst_after_line: got %h want %h", last_ret, line_of()); end
   endtask
   initial begin
      for (int i = 0; i < 8; i++) words[i] = 32'd0;
      test_reset;
      test_cached;
      test_back_to_back;
      test_uncached;
      test_flush_ar;
      test_flush_resp;
      test_random;
      test_reset_mid_burst;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
